sim_mem_arbiter: RTL

- Parametrised simulation memory front-end that replaces hard-wired per-port RAMHelper hookups in the simulation top.
- Arbitrates NUM_CH core cache command channels round-robin onto one RAMHelper-style RAM port.
- Generates byte write masks, rebases addresses to word indices and range-checks them.
- Returns read data to the originating channel after a configurable RD_LATENCY pipeline. Writes return no response.

---
 rtl/sim_mem_arbiter_if.sv | 36 +++
 rtl/sim_mem_arbiter.sv | 111 +++++++++++
 2 files changed

// File: rtl/sim_mem_arbiter_if.sv
// sim_mem_arbiter_if: channel command/response bundle plus the RAMHelper-style RAM port.
interface sim_mem_arbiter_if #(
   parameter int NUM_CH = 2,
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int IDX_W  = 28
);
   logic [NUM_CH-1:0]          ch_cmd_valid;
   logic [NUM_CH-1:0]          ch_cmd_ready;
   logic [NUM_CH*ADDR_W-1:0]   ch_cmd_addr;
   logic [NUM_CH-1:0]          ch_cmd_wen;
   logic [NUM_CH*DATA_W-1:0]   ch_cmd_wdata;
   logic [NUM_CH*DATA_W/8-1:0] ch_cmd_wstrb;
   logic [NUM_CH-1:0]          ch_rsp_valid;
   logic [NUM_CH*DATA_W-1:0]   ch_rsp_data;
   logic [NUM_CH-1:0]          ch_rsp_err;
   logic                       ram_en;
   logic [IDX_W-1:0]           ram_ridx;
   logic [DATA_W-1:0]          ram_rdata;
   logic [IDX_W-1:0]           ram_widx;
   logic [DATA_W-1:0]          ram_wdata;
   logic [DATA_W-1:0]          ram_wmask;
   logic                       ram_wen;

   modport master (
      output ch_cmd_valid, ch_cmd_addr, ch_cmd_wen, ch_cmd_wdata, ch_cmd_wstrb, ram_rdata,
      input  ch_cmd_ready, ch_rsp_valid, ch_rsp_data, ch_rsp_err,
      input  ram_en, ram_ridx, ram_widx, ram_wdata, ram_wmask, ram_wen
   );

   modport slave (
      input  ch_cmd_valid, ch_cmd_addr, ch_cmd_wen, ch_cmd_wdata, ch_cmd_wstrb, ram_rdata,
      output ch_cmd_ready, ch_rsp_valid, ch_rsp_data, ch_rsp_err,
      output ram_en, ram_ridx, ram_widx, ram_wdata, ram_wmask, ram_wen
   );
endinterface

// File: rtl/sim_mem_arbiter.sv
// sim_mem_arbiter: round-robin arbiter of NUM_CH cache command channels onto one RAMHelper-style port.
module sim_mem_arbiter #(
   parameter int          NUM_CH     = 2,
   parameter int          ADDR_W     = 64,
   parameter int          DATA_W     = 64,
   parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
   parameter int          IDX_W      = 28,
   parameter int          RD_LATENCY = 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             stall,
   sim_mem_arbiter_if.slave bus,
   output logic [31:0]      grant_cnt,
   output logic [31:0]      err_cnt
);
   localparam int BW = DATA_W / 8;
   localparam int SH = $clog2(BW);
   localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

   typedef struct packed {
      logic              v;
      logic [CW-1:0]     ch;
      logic              err;
      logic [DATA_W-1:0] data;
   } ent_t;

   logic [CW-1:0]     ptr, g, c;
   logic              gnt, err, wen;
   logic [ADDR_W-1:0] addr, off;
   logic [IDX_W-1:0]  idx;
   logic [DATA_W-1:0] wdata, mask;
   logic [BW-1:0]     strb;
   ent_t              pipe [RD_LATENCY];
   ent_t              tail;

   always_comb begin
      gnt = 1'b0;
      g = '0;
      c = '0;
      // Scan downward so the lowest offset from ptr is the last (winning) assignment.
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         c = CW'((int'(ptr) + k) % NUM_CH);
         if (bus.ch_cmd_valid[c]) begin
            gnt = 1'b1;
            g = c;
         end
      end
      gnt = gnt & ~stall & reset_n;
      addr = '0;
      wen = 1'b0;
      wdata = '0;
      strb = '0;
      bus.ch_cmd_ready = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (CW'(i) == g) begin
            addr = bus.ch_cmd_addr[i*ADDR_W +: ADDR_W];
            wen = bus.ch_cmd_wen[i];
            wdata = bus.ch_cmd_wdata[i*DATA_W +: DATA_W];
            strb = bus.ch_cmd_wstrb[i*BW +: BW];
            bus.ch_cmd_ready[i] = gnt;
         end
      off = addr - BASE;
      err = addr < BASE || |(off >> (IDX_W + SH));
      idx = IDX_W'(off >> SH);
      mask = '0;
      for (int b = 0; b < BW; b++)
         mask[b*8 +: 8] = {8{strb[b]}};
      bus.ram_en = gnt & ~err;
      bus.ram_wen = gnt & wen & ~err;
      bus.ram_ridx = gnt ? idx : '0;
      bus.ram_widx = gnt ? idx : '0;
      bus.ram_wdata = gnt ? wdata : '0;
      bus.ram_wmask = gnt ? mask : '0;
      tail.v = gnt & ~wen;
      tail.ch = g;
      tail.err = err;
      tail.data = err ? '0 : bus.ram_rdata;
   end

   always_comb begin
      bus.ch_rsp_valid = '0;
      bus.ch_rsp_err = '0;
      bus.ch_rsp_data = '0;
      for (int i = 0; i < NUM_CH; i++)
         if (pipe[RD_LATENCY-1].v && pipe[RD_LATENCY-1].ch == CW'(i)) begin
            bus.ch_rsp_valid[i] = 1'b1;
            bus.ch_rsp_err[i] = pipe[RD_LATENCY-1].err;
            bus.ch_rsp_data[i*DATA_W +: DATA_W] = pipe[RD_LATENCY-1].data;
         end
   end

   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         ptr <= '0;
         grant_cnt <= '0;
         err_cnt <= '0;
         for (int s = 0; s < RD_LATENCY; s++)
            pipe[s] <= '0;
      end else begin
         if (gnt) begin
            ptr <= int'(g) == NUM_CH - 1 ? '0 : g + 1'b1;
            grant_cnt <= grant_cnt + 1'b1;
            err_cnt <= err_cnt + 32'(err);
         end
         pipe[0] <= tail;
         for (int s = 1; s < RD_LATENCY; s++)
            pipe[s] <= pipe[s-1];
      end
endmodule
